// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Shifts a WIDTH-bit operand left or right in logical, arithmetic or rotate
//   mode. Shifting is split into SHW = log2(WIDTH) registered stages; stage k
//   shifts by 2^k when bit k of the op's shift amount is set. The last stage
//   is the output register. One op per clock, with full backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation can be accepted this cycle (depends only on the output side)
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_dir     0 = left, 1 = right
//   in_mode    00 logical, 01 arithmetic, 10 rotate, 11 treated as logical
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   shifted result
//   out_zero   out_data == 0, meaningful while out_valid is high
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  // Per-stage registers; index SHW-1 is the output register.
  logic             r_valid [SHW];
  logic [WIDTH-1:0] r_data  [SHW];
  logic [SHW-1:0]   r_shamt [SHW];
  logic             r_dir   [SHW];
  logic [1:0]       r_mode  [SHW];
  logic             r_sign  [SHW];
  logic             r_zero;

  // Inputs of each stage: stage 0 sees the port, stage k sees stage k-1.
  logic             w_src_valid [SHW];
  logic [WIDTH-1:0] w_src_data  [SHW];
  logic [SHW-1:0]   w_src_shamt [SHW];
  logic             w_src_dir   [SHW];
  logic [1:0]       w_src_mode  [SHW];
  logic             w_src_sign  [SHW];
  logic [WIDTH-1:0] w_shifted   [SHW];

  logic w_advance;
  logic w_unused;

  // The whole pipe moves as one; a stalled output freezes every stage, so
  // bubbles are never collapsed and in_ready never depends on in_valid.
  assign w_advance = !r_valid[SHW-1] || out_ready;
  assign in_ready  = w_advance;

  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_zero  = r_zero;

  // Control fields carried by the output register are not consumed further.
  assign w_unused = ^{r_shamt[SHW-1], r_dir[SHW-1], r_mode[SHW-1], r_sign[SHW-1]};

  always_comb begin
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    w_src_shamt[0] = in_shamt;
    w_src_dir[0]   = in_dir;
    w_src_mode[0]  = in_mode;
    // Arithmetic fill must come from the original operand, so capture it here.
    w_src_sign[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_shamt[k] = r_shamt[k-1];
      w_src_dir[k]   = r_dir[k-1];
      w_src_mode[k]  = r_mode[k-1];
      w_src_sign[k]  = r_sign[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      w_shifted[k] = w_src_data[k];
      if (w_src_shamt[k][k]) begin
        if (!w_src_dir[k]) begin
          // Arithmetic left is the same as logical left.
          if (w_src_mode[k] == MODE_ROTATE)
            w_shifted[k] = (w_src_data[k] << (1 << k)) | (w_src_data[k] >> (WIDTH - (1 << k)));
          else
            w_shifted[k] = w_src_data[k] << (1 << k);
        end else begin
          case (w_src_mode[k])
            MODE_ARITH:
              w_shifted[k] = (w_src_data[k] >> (1 << k)) |
                             ({WIDTH{w_src_sign[k]}} << (WIDTH - (1 << k)));
            MODE_ROTATE:
              w_shifted[k] = (w_src_data[k] >> (1 << k)) | (w_src_data[k] << (WIDTH - (1 << k)));
            default:
              w_shifted[k] = w_src_data[k] >> (1 << k);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_dir[k]   <= 1'b0;
        r_mode[k]  <= 2'b00;
        r_sign[k]  <= 1'b0;
      end
      r_zero <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < SHW; k++) begin
        r_valid[k] <= w_src_valid[k];
        r_data[k]  <= w_shifted[k];
        r_shamt[k] <= w_src_shamt[k];
        r_dir[k]   <= w_src_dir[k];
        r_mode[k]  <= w_src_mode[k];
        r_sign[k]  <= w_src_sign[k];
      end
      r_zero <= w_src_valid[SHW-1] && (w_shifted[SHW-1] == '0);
    end
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 8-bit combinational barrel shifter. It performs left or right shifts in logical, arithmetic or rotate mode on a WIDTH-bit operand. There is one registered mux level per shift-amount bit. A valid/ready handshake on both sides gives throughput of one op per cycle and full backpressure. It sits in the datapath between operand staging and the ALU result mux.

Parameters:
WIDTH, 8, operand width in bits; must be a power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width and pipeline depth (STAGES = SHW); derived, not overridden

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operation valid
in_ready  output  1  block can accept an operation this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHW  shift amount, 0..WIDTH-1
in_dir  input  1  0 = left, 1 = right
in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result
out_zero  output  1  high when out_data == 0; qualified by out_valid

Behaviour:
- Reset (async assert, sync release): all stage valids 0; out_valid=0, out_data=0, out_zero=0; in_ready=1 after reset.
- Pipeline: stage k (k=0..SHW-1) applies a shift of 2^k when bit k of the op's shamt is 1, else passes through. Each stage registers valid, data, shamt, dir and mode.
- Output stage: the last stage is the output register; out_zero is registered alongside out_data.
- advance = !out_valid || out_ready. in_ready = advance (combinational). All stages load on the same edge only when advance=1. When advance=0 every stage holds its state.
- Accept: an op is accepted at a rising edge with in_valid && in_ready. Its result appears on out_data/out_valid after SHW-1 further advancing edges (WIDTH=8: accept at edge t, out_valid high after edge t+2 with no stall). Sustained throughput is one op per clk.
- Bubbles: an edge with advance=1 and no accepted op inserts valid=0 into stage 0. Bubbles are not collapsed.
- Logical left/right: zero fill.
- Arithmetic right: fills with in_data[WIDTH-1] of the original operand. The sign bit travels with the op.
- Arithmetic left: identical to logical left.
- Rotate: bits shifted out re-enter at the opposite end.
- Mode 11: identical to logical. No error flag.
- shamt=0: out_data = in_data for all modes and directions.
- Stall: while out_valid=1 and out_ready=0, out_data, out_zero and all internal stages are held stable. Input changes are ignored because in_ready=0.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: the output retires, all stages shift, and the new op enters stage 0 on the same edge.
- Reset mid-operation: all in-flight ops are discarded; out_valid drops to 0 immediately (asynchronous). No partial result is emitted after release.
- in_ready is independent of in_valid; there is no combinational path from in_valid to in_ready.

Test Plan:
- WIDTH=8, out_ready=1: in_data=11110000, shamt=3, dir=0, mode=00 -> out_data=10000000, out_zero=0, out_valid 2 edges after accept.
- in_data=11110000, shamt=2, dir=1, mode=01 -> 11111100; same operand with mode=00 -> 00111100; in_data=00011111, shamt=2, dir=1, mode=01 -> 00000111.
- in_data=10101010, shamt=3, dir=1, mode=10 -> 01010101; shamt=7, dir=0, mode=10 on 11001100 -> 01100110; shamt=0, any mode -> output equals input.
- Back-to-back, 4 ops on consecutive cycles with out_ready=1 -> 4 results on consecutive cycles in order. Then hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_data stable, no op lost or duplicated after release.
- in_data=11110000, shamt=4, dir=0, mode=00 -> out_data=00000000, out_zero=1. Repeat with mode=11 -> identical result.
- Pulse rst_n low with 2 ops in flight -> out_valid=0 immediately. After release, in_ready=1 and no stale result ever appears.
